mem_arbiter: RTL and testbench

Shares one unified single-port memory between the processor's instruction-fetch port and its data port. It accepts level-held requests from both sides, grants them one at a time with round-robin fairness, and drives a registered request/acknowledge handshake to memory. It routes read data and a one-cycle acknowledge back to the winner and aborts stalled accesses with a watchdog. It sits between the `mips` core's `pc`/`instr` and `aluout`/`writedata`/`readdata`/`memwrite` signals and the shared memory model.

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and data ports, with registered memory handshake and a stall watchdog.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic          i_err,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic          d_err,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          busy
);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

    state_t         state;
    logic           last_d;   // 1 = data side won the previous grant
    logic [WDW-1:0] wd;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            last_d  <= 1'b1;
            wd      <= '0;
            i_ack   <= 1'b0;
            i_err   <= 1'b0;
            i_rdata <= '0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            d_rdata <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            i_ack <= 1'b0;
            i_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req && (!d_req || last_d)) begin
                        state   <= I_BUSY;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= i_addr;
                        m_wdata <= '0;
                        last_d  <= 1'b0;
                        wd      <= '0;
                    end else if (d_req) begin
                        state   <= D_BUSY;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        last_d  <= 1'b1;
                        wd      <= '0;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        state <= RESP;
                        if (state == I_BUSY) begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            if (!m_we) d_rdata <= m_rdata;
                        end
                    end else if (wd == WD_LAST) begin
                        // watchdog expiry: abort with error, read data untouched
                        m_req <= 1'b0;
                        state <= RESP;
                        if (state == I_BUSY) begin
                            i_ack <= 1'b1;
                            i_err <= 1'b1;
                        end else begin
                            d_ack <= 1'b1;
                            d_err <= 1'b1;
                        end
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level schedule model predicts
// every output each cycle while the bench plays both requesters and the memory.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack, i_err;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack, d_err;
    logic [DW-1:0] d_rdata;
    logic          m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ack = 1'b0;
    logic          busy;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction model: one access in flight, granted at edge g, m_req held
    // for L cycles, ack in cycle g+L, idle again from g+L+1.
    bit            act = 1'b0;
    bit            last_d = 1'b1;
    int            g, L, W;
    bit            own_d, t_we, t_err;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_rdata;
    logic [DW-1:0] e_irdata = '0, e_drdata = '0;
    int            cyc = 0;

    task automatic chk_zero(input string tag);
        chk({tag, ".m_req"}, m_req, 0);
        chk({tag, ".m_we"}, m_we, 0);
        chk({tag, ".m_addr"}, m_addr, 0);
        chk({tag, ".m_wdata"}, m_wdata, 0);
        chk({tag, ".acks"}, {i_ack, d_ack, i_err, d_err}, 0);
        chk({tag, ".rdata"}, {i_rdata, d_rdata}, 0);
        chk({tag, ".busy"}, busy, 0);
    endtask

    task automatic check_cycle(input int n);
        bit mreq, ack;
        if (act && n > g + L) act = 1'b0;
        mreq = act && (n <= g + L - 1);
        ack  = act && (n == g + L);
        if (ack && !t_err && !t_we) begin
            if (own_d) e_drdata = t_rdata;
            else       e_irdata = t_rdata;
        end
        chk("m_req", m_req, mreq);
        if (mreq) begin
            chk("m_addr", m_addr, t_addr);
            chk("m_we", m_we, t_we);
            chk("m_wdata", m_wdata, t_wdata);
        end
        chk("i_ack", i_ack, ack && !own_d);
        chk("d_ack", d_ack, ack && own_d);
        chk("i_err", i_err, ack && !own_d && t_err);
        chk("d_err", d_err, ack && own_d && t_err);
        chk("busy", busy, act);
        chk("i_rdata", i_rdata, e_irdata);
        chk("d_rdata", d_rdata, e_drdata);
    endtask

    task automatic drive_cycle(input int n);
        int r;
        bit contend;
        contend = (n < 60);
        i_req   = contend ? 1'b1 : ($urandom_range(0, 9) < 6);
        d_req   = contend ? 1'b1 : ($urandom_range(0, 9) < 6);
        i_addr  = $urandom;
        d_we    = $urandom_range(0, 1);
        d_addr  = $urandom;
        d_wdata = $urandom;
        m_rdata = $urandom;
        if (act && n >= g && n <= g + L - 1) begin
            m_ack = (n == g + W);
            if (n == g + W) t_rdata = m_rdata;
        end else begin
            m_ack = $urandom_range(0, 1);
        end
        if (!act && (i_req || d_req)) begin
            own_d   = !(i_req && (!d_req || last_d));
            last_d  = own_d;
            act     = 1'b1;
            g       = n + 1;
            t_we    = own_d ? d_we : 1'b0;
            t_addr  = own_d ? d_addr : i_addr;
            t_wdata = own_d ? d_wdata : '0;
            r = $urandom_range(0, 9);
            if (contend)    W = 0;
            else if (r < 5) W = $urandom_range(0, 2);
            else if (r < 8) W = $urandom_range(3, T);
            else            W = $urandom_range(T, T + 3);
            L     = (W + 1 <= T) ? W + 1 : T;
            t_err = (W >= T);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        for (int it = 0; it < 3000; it++) begin
            @(negedge clk);
            cyc++;
            if (act && it > 60 && $urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                #1;
                act      = 1'b0;
                last_d   = 1'b1;
                e_irdata = '0;
                e_drdata = '0;
                chk_zero("midreset");
                continue;
            end
            reset = 1'b1;
            check_cycle(cyc);
            drive_cycle(cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
